// File: rtl/regfile_multiport.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational read ports,
// optional write-to-read bypass, optional hardwired zero entry and a per-entry busy scoreboard.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     bset_en,
    input  logic [ADDR_W-1:0]        bset_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              bset_ok;

    // Entry 0 swallows writes and busy sets when it is hardwired to zero.
    assign wr0_ok  = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok  = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign bset_ok = bset_en && !((ZERO_REG != 0) && (bset_addr == '0));

    always_comb begin
        busy_nxt = busy;
        if (wr0_ok) busy_nxt[waddr0] = 1'b0;
        if (wr1_ok) busy_nxt[waddr1] = 1'b0;
        // A newly issued producer supersedes the one completing this cycle.
        if (bset_ok) busy_nxt[bset_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr0_ok) mem[waddr0] <= wdata0;
            // Port 1 is written last so it wins an address collision.
            if (wr1_ok) mem[waddr1] <= wdata1;
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              bz;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
            bz = busy[ra];
            if (BYPASS != 0) begin
                if (wr0_ok && (waddr0 == ra)) begin
                    rd = wdata0;
                    bz = 1'b0;
                end
                if (wr1_ok && (waddr1 == ra)) begin
                    rd = wdata1;
                    bz = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
                bz = 1'b0;
            end
            if (!rst) begin
                rd = '0;
                bz = 1'b0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
        assign rbusy[k]                  = bz;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: one instance with zero register and bypass,
// one with both disabled, sharing the same stimulus.
module tb_regfile_multiport;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     we0, we1, bset_en;
    logic [ADDR_W-1:0]        waddr0, waddr1, bset_addr;
    logic [DATA_W-1:0]        wdata0, wdata1;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata_a, rdata_b;
    logic [NUM_RD-1:0]        rbusy_a, rbusy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                        .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .bset_en(bset_en), .bset_addr(bset_addr)
    );

    regfile_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                        .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .bset_en(bset_en), .bset_addr(bset_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; bset_en = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle();
        waddr0 = '0; waddr1 = '0; bset_addr = '0;
        wdata0 = '0; wdata1 = '0;
        rd(5'd5, 5'd6);
        #2;
        rst = 1'b1;
        tick();

        // Prior activity, then asynchronous reset between edges
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h12345678;
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h87654321;
        bset_en = 1'b1; bset_addr = 5'd6;
        tick();
        idle();
        #1;
        chk("pre_reset_b", rdata_b, 64'h87654321_12345678);
        chk("pre_reset_busy_b", {62'd0, rbusy_b}, 64'h2);
        rst = 1'b0;
        #1;
        chk("in_reset_rdata_a", rdata_a, 64'h0);
        chk("in_reset_rdata_b", rdata_b, 64'h0);
        chk("in_reset_rbusy_b", {62'd0, rbusy_b}, 64'h0);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            #1;
            chk("post_reset_rdata_b", rdata_b, 64'h0);
            chk("post_reset_rbusy_b", {62'd0, rbusy_b}, 64'h0);
        end
        tick();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        idle();
        rd(5'd5, 5'd5);
        #1;
        chk("x5_after_reset_a", rdata_a, 64'hDEADBEEF_DEADBEEF);
        chk("x5_after_reset_b", rdata_b, 64'hDEADBEEF_DEADBEEF);

        // Dual-write conflict on x7
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        rd(5'd7, 5'd5);
        #1;
        chk("dual_bypass_a", rdata_a, 64'hDEADBEEF_22222222);
        chk("dual_nobypass_b", rdata_b, 64'hDEADBEEF_00000000);
        tick();
        idle();
        #1;
        chk("dual_stored_a", rdata_a, 64'hDEADBEEF_22222222);
        chk("dual_stored_b", rdata_b, 64'hDEADBEEF_22222222);

        // Zero register
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        bset_en = 1'b1; bset_addr = 5'd0;
        rd(5'd0, 5'd0);
        #1;
        chk("zero_same_a", rdata_a, 64'h0);
        chk("zero_same_busy_a", {62'd0, rbusy_a}, 64'h0);
        tick();
        idle();
        #1;
        chk("zero_next_a", rdata_a, 64'h0);
        chk("zero_next_busy_a", {62'd0, rbusy_a}, 64'h0);
        chk("nozero_b", rdata_b, 64'hFFFFFFFF_FFFFFFFF);
        chk("nozero_busy_b", {62'd0, rbusy_b}, 64'h3);

        // Bypass on vs off
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h00000042;
        rd(5'd3, 5'd7);
        #1;
        chk("bypass_on_a", rdata_a, 64'h22222222_00000042);
        chk("bypass_off_b", rdata_b, 64'h22222222_00000000);
        tick();
        idle();
        #1;
        chk("bypass_next_b", rdata_b, 64'h22222222_00000042);

        // Scoreboard on x9
        bset_en = 1'b1; bset_addr = 5'd9;
        rd(5'd9, 5'd9);
        #1;
        chk("bset_same_a", {62'd0, rbusy_a}, 64'h0);
        tick();
        idle();
        #1;
        chk("bset_next_a", {62'd0, rbusy_a}, 64'h3);
        chk("bset_next_b", {62'd0, rbusy_b}, 64'h3);
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hA5A5A5A5;
        #1;
        chk("wr_clear_same_a", {62'd0, rbusy_a}, 64'h0);
        chk("wr_clear_same_b", {62'd0, rbusy_b}, 64'h3);
        tick();
        idle();
        #1;
        chk("wr_clear_next_a", {62'd0, rbusy_a}, 64'h0);
        chk("wr_clear_next_b", {62'd0, rbusy_b}, 64'h0);
        chk("wr_data_b", rdata_b, 64'hA5A5A5A5_A5A5A5A5);
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h5A5A5A5A;
        bset_en = 1'b1; bset_addr = 5'd9;
        tick();
        idle();
        #1;
        chk("set_wins_busy_a", {62'd0, rbusy_a}, 64'h3);
        chk("set_wins_busy_b", {62'd0, rbusy_b}, 64'h3);
        chk("set_wins_data_a", rdata_a, 64'h5A5A5A5A_5A5A5A5A);
        chk("set_wins_data_b", rdata_b, 64'h5A5A5A5A_5A5A5A5A);

        // Asynchronous reset mid-cycle with a pending write to x4
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44444444;
        tick();
        idle();
        rd(5'd4, 5'd9);
        #1;
        chk("x4_before_b", rdata_b, 64'h5A5A5A5A_44444444);
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h99999999;
        #1;
        rst = 1'b0;
        #1;
        chk("mid_reset_rdata_a", rdata_a, 64'h0);
        chk("mid_reset_rdata_b", rdata_b, 64'h0);
        chk("mid_reset_rbusy_a", {62'd0, rbusy_a}, 64'h0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("x4_discard_a", rdata_a, 64'h0);
        chk("x4_discard_b", rdata_b, 64'h0);
        chk("busy_cleared_b", {62'd0, rbusy_b}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
